branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer_if.sv | 37 +++
 rtl/branch_sequencer.sv | 143 ++++++++++++++
 tb/tb_branch_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Bus between the branch sequencer and its surroundings: the request and
// operands, the ECX write-back port, the fetch redirect handshake and completion.
interface branch_sequencer_if;
   logic        start_i;
   logic [7:0]  opcode_i;
   logic [7:0]  disp_i;
   logic [31:0] eip_i;
   logic [31:0] ecx_i;
   logic        db_i;
   logic        zf_i;
   logic        cf_i;
   logic        sf_i;
   logic        vf_i;
   logic        pf_i;
   logic        redirect_ack_i;
   logic        busy_o;
   logic [31:0] ecx_o;
   logic        ecx_we_o;
   logic        redirect_o;
   logic [31:0] target_o;
   logic        done_o;
   logic        taken_o;

   // Requester side: issues branches, acknowledges redirects.
   modport master (
      output start_i, opcode_i, disp_i, eip_i, ecx_i, db_i,
      output zf_i, cf_i, sf_i, vf_i, pf_i, redirect_ack_i,
      input  busy_o, ecx_o, ecx_we_o, redirect_o, target_o, done_o, taken_o
   );

   // Sequencer side.
   modport slave (
      input  start_i, opcode_i, disp_i, eip_i, ecx_i, db_i,
      input  zf_i, cf_i, sf_i, vf_i, pf_i, redirect_ack_i,
      output busy_o, ecx_o, ecx_we_o, redirect_o, target_o, done_o, taken_o
   );
endinterface

// File: rtl/branch_sequencer.sv
// Short-branch sequencer: executes Jcc/JMPS/LOOPcc/JCXZ with rel8 displacement.
// Operands are captured on start, LOOP-family opcodes decrement ECX (CX when
// db=0), the outcome is evaluated from the captured flags, and a taken branch
// holds a fetch redirect until acknowledged before signalling completion.
module branch_sequencer (
   input logic               clk_i,
   input logic               rst_i,
   branch_sequencer_if.slave bus
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StDecr  = 3'd1;
   localparam logic [2:0] StEval  = 3'd2;
   localparam logic [2:0] StRedir = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [7:0]  op_q;
   logic [7:0]  disp_q;
   logic [31:0] eip_q;
   logic [31:0] ecx_q;
   logic        db_q;
   logic        zf_q, cf_q, sf_q, vf_q, pf_q;
   logic        taken_q, taken_d;

   logic        start_loop;
   logic [31:0] ecx_dec;
   logic        cnt_nz;
   logic        cx_zero;
   logic [31:0] target_sum;
   logic [31:0] target;
   logic        jcc_hit;
   logic        eval_taken;

   // E0h-E2h are the LOOP family; E3h (JCXZ) reads the count but never writes it.
   assign start_loop = (bus.opcode_i[7:2] == 6'b111000) && (bus.opcode_i[1:0] != 2'b11);

   // With 16-bit addressing the decrement wraps inside CX and leaves ECX[31:16] alone.
   assign ecx_dec = db_q ? (ecx_q - 32'd1) : {ecx_q[31:16], ecx_q[15:0] - 16'd1};
   assign cnt_nz  = db_q ? (ecx_dec != 32'd0) : (ecx_dec[15:0] != 16'd0);
   assign cx_zero = db_q ? (ecx_q == 32'd0) : (ecx_q[15:0] == 16'd0);

   assign target_sum = eip_q + {{24{disp_q[7]}}, disp_q};
   assign target     = db_q ? target_sum : {16'h0000, target_sum[15:0]};

   // Branch outcome from captured opcode, flags and count.
   always_comb begin
      jcc_hit    = 1'b0;
      eval_taken = 1'b0;
      case (op_q[3:1])
         3'd0:    jcc_hit = vf_q;
         3'd1:    jcc_hit = cf_q;
         3'd2:    jcc_hit = zf_q;
         3'd3:    jcc_hit = cf_q | zf_q;
         3'd4:    jcc_hit = sf_q;
         3'd5:    jcc_hit = pf_q;
         3'd6:    jcc_hit = sf_q ^ vf_q;
         default: jcc_hit = (sf_q ^ vf_q) | zf_q;
      endcase
      if (op_q[7:4] == 4'h7) begin
         // Odd Jcc opcodes test the inverse condition.
         eval_taken = jcc_hit ^ op_q[0];
      end else begin
         case (op_q)
            8'hEB:   eval_taken = 1'b1;
            8'hE0:   eval_taken = cnt_nz & ~zf_q;
            8'hE1:   eval_taken = cnt_nz & zf_q;
            8'hE2:   eval_taken = cnt_nz;
            8'hE3:   eval_taken = cx_zero;
            default: eval_taken = 1'b0;
         endcase
      end
   end

   // Next-state and outcome latch selection.
   always_comb begin
      state_d = state_q;
      taken_d = taken_q;
      case (state_q)
         StIdle: begin
            if (bus.start_i) begin
               state_d = start_loop ? StDecr : StEval;
               taken_d = 1'b0;
            end
         end
         StDecr:  state_d = StEval;
         StEval: begin
            taken_d = eval_taken;
            state_d = eval_taken ? StRedir : StDone;
         end
         StRedir: begin
            if (bus.redirect_ack_i) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, outcome and operand capture; operands load only on an accepted start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         taken_q <= 1'b0;
         op_q    <= 8'h00;
         disp_q  <= 8'h00;
         eip_q   <= 32'h0;
         ecx_q   <= 32'h0;
         db_q    <= 1'b0;
         zf_q    <= 1'b0;
         cf_q    <= 1'b0;
         sf_q    <= 1'b0;
         vf_q    <= 1'b0;
         pf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         taken_q <= taken_d;
         if (state_q == StIdle && bus.start_i) begin
            op_q   <= bus.opcode_i;
            disp_q <= bus.disp_i;
            eip_q  <= bus.eip_i;
            ecx_q  <= bus.ecx_i;
            db_q   <= bus.db_i;
            zf_q   <= bus.zf_i;
            cf_q   <= bus.cf_i;
            sf_q   <= bus.sf_i;
            vf_q   <= bus.vf_i;
            pf_q   <= bus.pf_i;
         end
      end
   end

   // Outputs decode from registered state, so reset clears them immediately.
   assign bus.busy_o     = (state_q != StIdle);
   assign bus.ecx_we_o   = (state_q == StDecr);
   assign bus.ecx_o      = (state_q == StDecr) ? ecx_dec : 32'h0;
   assign bus.redirect_o = (state_q == StRedir);
   assign bus.target_o   = target;
   assign bus.done_o     = (state_q == StDone);
   assign bus.taken_o    = (state_q == StDone) & taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: stimulus pushes expected ECX writes,
// redirect targets and completions; a negedge monitor pops and compares them.
module tb_branch_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic resp_ack = 1'b0;
   logic stray_ack = 1'b0;
   int   ack_wait = 0;
   int   wait_cnt = 0;
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;

   typedef struct {
      logic taken;
      int   cyc;
   } done_t;

   done_t       done_q[$];
   logic [31:0] ecx_exp_q[$];
   logic [31:0] tgt_exp_q[$];
   logic [31:0] cur_target = 32'h0;
   logic        redir_prev = 1'b0;

   branch_sequencer_if bus ();

   branch_sequencer dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   assign bus.redirect_ack_i = resp_ack | stray_ack;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_evt(input string name);
      total++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   // Fetch-side responder: acks after ack_wait REDIR cycles.
   always @(negedge clk) begin
      if (rst) begin
         resp_ack = 1'b0;
         wait_cnt = 0;
      end else if (bus.redirect_o) begin
         resp_ack = (wait_cnt >= ack_wait);
         wait_cnt++;
      end else begin
         resp_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   // Monitor: compares every output event against the scoreboard queues.
   always @(negedge clk) begin
      if (rst) begin
         redir_prev = 1'b0;
      end else begin
         if (bus.ecx_we_o) begin
            if (ecx_exp_q.size() == 0) fail_evt("ecx_we_o");
            else chk("ecx_o", bus.ecx_o, ecx_exp_q.pop_front());
         end
         if (bus.redirect_o) begin
            if (!redir_prev) begin
               if (tgt_exp_q.size() == 0) begin
                  fail_evt("redirect_o");
                  cur_target = bus.target_o;
               end else begin
                  cur_target = tgt_exp_q.pop_front();
               end
            end
            chk("target_o", bus.target_o, cur_target);
         end
         redir_prev = bus.redirect_o;
         if (bus.done_o) begin
            if (done_q.size() == 0) begin
               fail_evt("done_o");
            end else begin
               done_t d;
               d = done_q.pop_front();
               chk("taken_o", {31'h0, bus.taken_o}, {31'h0, d.taken});
               chk("done_cycle", cyc, d.cyc);
            end
         end
      end
   end

   task automatic drive(input logic [7:0] op, input logic [7:0] disp, input logic [31:0] eip,
                        input logic [31:0] ecx, input logic db, input logic [4:0] fl);
      bus.opcode_i = op;
      bus.disp_i   = disp;
      bus.eip_i    = eip;
      bus.ecx_i    = ecx;
      bus.db_i     = db;
      {bus.zf_i, bus.cf_i, bus.sf_i, bus.vf_i, bus.pf_i} = fl;
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!bus.busy_o) begin
            idle = 1'b1;
            break;
         end
      end
      if (!idle) fail_evt("busy_timeout");
   endtask

   // fl = {zf, cf, sf, vf, pf}; lat counts cycles from the start edge to done_o.
   task automatic issue(input logic [7:0] op, input logic [7:0] disp, input logic [31:0] eip,
                        input logic [31:0] ecx, input logic db, input logic [4:0] fl,
                        input logic tk, input int lat, input logic we,
                        input logic [31:0] ecx_exp, input logic [31:0] tgt, input int aw);
      done_t d;
      ack_wait = aw;
      drive(op, disp, eip, ecx, db, fl);
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      d.taken = tk;
      d.cyc   = cyc + lat - 1;
      done_q.push_back(d);
      if (we) ecx_exp_q.push_back(ecx_exp);
      if (tk) tgt_exp_q.push_back(tgt);
      wait_idle();
   endtask

   initial begin
      done_t d;
      bus.start_i = 1'b0;
      drive(8'h00, 8'h00, 32'h0, 32'h0, 1'b0, 5'b0);
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'h0, bus.busy_o}, 32'h0);
      chk("rst_ecx_o", bus.ecx_o, 32'h0);
      chk("rst_ecx_we", {31'h0, bus.ecx_we_o}, 32'h0);
      chk("rst_redirect", {31'h0, bus.redirect_o}, 32'h0);
      chk("rst_target", bus.target_o, 32'h0);
      chk("rst_done", {31'h0, bus.done_o}, 32'h0);
      chk("rst_taken", {31'h0, bus.taken_o}, 32'h0);
      rst = 1'b0;

      // JE taken, first start right after reset release
      issue(8'h74, 8'hFE, 32'h0000_1000, 32'h0, 1'b1, 5'b10000, 1'b1, 3, 1'b0, 32'h0,
            32'h0000_0FFE, 0);
      // LOOP count 1 -> 0, not taken
      issue(8'hE2, 8'h10, 32'h0000_2000, 32'h0000_0001, 1'b1, 5'b0, 1'b0, 3, 1'b1, 32'h0,
            32'h0, 0);
      // LOOPNZ 16-bit wrap, target wraps within 64K
      issue(8'hE0, 8'h20, 32'h0000_FFF0, 32'h1234_0000, 1'b0, 5'b0, 1'b1, 4, 1'b1,
            32'h1234_FFFF, 32'h0000_0010, 0);
      // JCXZ: CX zero in 16-bit mode, ECX nonzero in 32-bit mode
      issue(8'hE3, 8'h05, 32'h0000_3000, 32'h0001_0000, 1'b0, 5'b0, 1'b1, 3, 1'b0, 32'h0,
            32'h0000_3005, 0);
      issue(8'hE3, 8'h05, 32'h0000_3000, 32'h0001_0000, 1'b1, 5'b0, 1'b0, 2, 1'b0, 32'h0,
            32'h0, 0);
      // JNE with zf=1: not taken
      issue(8'h75, 8'h10, 32'h0000_0100, 32'h0, 1'b1, 5'b10000, 1'b0, 2, 1'b0, 32'h0,
            32'h0, 0);
      // JL with sf=1 vf=0, 16-bit, ack after 2 cycles
      issue(8'h7C, 8'h7F, 32'h0000_0100, 32'h0, 1'b0, 5'b00100, 1'b1, 5, 1'b0, 32'h0,
            32'h0000_017F, 2);
      // JA with cf=0 zf=0: taken ; JBE same flags: not taken
      issue(8'h77, 8'h01, 32'h8000_0000, 32'h0, 1'b1, 5'b00000, 1'b1, 3, 1'b0, 32'h0,
            32'h8000_0001, 0);
      issue(8'h76, 8'h01, 32'h8000_0000, 32'h0, 1'b1, 5'b00000, 1'b0, 2, 1'b0, 32'h0,
            32'h0, 0);
      // JNLE with sf=vf=1 zf=0: taken ; JP pf=0: not taken
      issue(8'h7F, 8'h80, 32'h0000_0200, 32'h0, 1'b1, 5'b00110, 1'b1, 3, 1'b0, 32'h0,
            32'h0000_0180, 0);
      issue(8'h7A, 8'h80, 32'h0000_0200, 32'h0, 1'b1, 5'b00000, 1'b0, 2, 1'b0, 32'h0,
            32'h0, 0);
      // Unknown opcode: not taken
      issue(8'h90, 8'h10, 32'h0000_0300, 32'h0000_0007, 1'b1, 5'b11111, 1'b0, 2, 1'b0, 32'h0,
            32'h0, 0);
      // LOOPZ zf=1 count 5 -> 4 taken ; LOOP 16-bit wrap preserving upper half
      issue(8'hE1, 8'hF0, 32'h0000_0500, 32'h0000_0005, 1'b1, 5'b10000, 1'b1, 4, 1'b1,
            32'h0000_0004, 32'h0000_04F0, 0);
      issue(8'hE2, 8'h00, 32'h0001_2345, 32'hABCD_0000, 1'b0, 5'b0, 1'b1, 4, 1'b1,
            32'hABCD_FFFF, 32'h0000_2345, 0);

      // JMPS with ack withheld 5 cycles, stray ack in EVAL, second start during REDIR
      ack_wait = 5;
      drive(8'hEB, 8'h80, 32'h0000_4000, 32'h0, 1'b1, 5'b0);
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      d.taken = 1'b1;
      d.cyc   = cyc + 7;
      done_q.push_back(d);
      tgt_exp_q.push_back(32'h0000_3F80);
      stray_ack = 1'b1;
      @(posedge clk);
      #1;
      stray_ack = 1'b0;
      drive(8'h74, 8'h10, 32'hDEAD_0000, 32'h0000_0003, 1'b1, 5'b10000);
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      wait_idle();

      // Reset during REDIR aborts the branch without done_o
      ack_wait = 100;
      drive(8'hEB, 8'h10, 32'h0000_6000, 32'h0, 1'b1, 5'b0);
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      tgt_exp_q.push_back(32'h0000_6010);
      repeat (3) @(negedge clk);
      chk("redir_before_rst", {31'h0, bus.redirect_o}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("redir_async_rst", {31'h0, bus.redirect_o}, 32'h0);
      chk("busy_async_rst", {31'h0, bus.busy_o}, 32'h0);
      chk("target_async_rst", bus.target_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      issue(8'h7D, 8'h04, 32'h0000_7000, 32'h0, 1'b1, 5'b00001, 1'b1, 3, 1'b0, 32'h0,
            32'h0000_7004, 0);

      repeat (3) @(negedge clk);
      chk("done_q_empty", done_q.size(), 32'h0);
      chk("ecx_q_empty", ecx_exp_q.size(), 32'h0);
      chk("tgt_q_empty", tgt_exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
